register_bank: RTL and testbench

- Parametrised multi-entry successor of the single 32-bit clock_valid-gated register.
- Holds DEPTH entries of WIDTH bits, with:
  - one byte-enabled write port;
  - two registered read ports;
  - a sequenced bulk-clear engine.
- Used as the CPU-side general register store and as scratch state for peripherals.
- All state advances only on cycles where clock_valid is 1.

---
 rtl/register_bank_if.sv | 27 ++
 rtl/register_bank.sv | 107 ++++++++++
 tb/tb_register_bank.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// rtl/register_bank_if.sv - write/read/clear bus bundle for register_bank
interface register_bank_if #(
    parameter int WIDTH  = 32,
    parameter int ADDR_W = 3
);
    logic                 write;
    logic [ADDR_W-1:0]    write_addr;
    logic [WIDTH-1:0]     write_data;
    logic [WIDTH/8-1:0]   byte_en;
    logic                 write_accept;
    logic                 clear;
    logic                 busy;
    logic [ADDR_W-1:0]    read_addr_a;
    logic [WIDTH-1:0]     read_data_a;
    logic [ADDR_W-1:0]    read_addr_b;
    logic [WIDTH-1:0]     read_data_b;

    modport master (
        output write, write_addr, write_data, byte_en, clear, read_addr_a, read_addr_b,
        input  write_accept, busy, read_data_a, read_data_b
    );

    modport slave (
        input  write, write_addr, write_data, byte_en, clear, read_addr_a, read_addr_b,
        output write_accept, busy, read_data_a, read_data_b
    );
endinterface

// File: rtl/register_bank.sv
// rtl/register_bank.sv - byte-enabled register bank, two registered read ports, bulk clear
// Optional macro REGISTER_BANK_READ_BYPASS_EN: reads return the same-cycle post-write value.
module register_bank #(
    parameter int               WIDTH       = 32,
    parameter int               DEPTH       = 8,
    parameter int               ADDR_W      = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clock_valid,
    register_bank_if.slave    bus
);
    localparam int               NB      = WIDTH / 8;
    localparam logic [ADDR_W:0]  W_DEPTH = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W-1:0] W_LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic {ST_IDLE, ST_CLEARING} state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_index;
    logic                r_busy;
    logic [WIDTH-1:0]    r_mem [DEPTH];
    logic [WIDTH-1:0]    r_rd_a;
    logic [WIDTH-1:0]    r_rd_b;

    logic                w_accept;
    logic [WIDTH-1:0]    w_old;
    logic [WIDTH-1:0]    w_merged;
    logic [WIDTH-1:0]    w_raw_a;
    logic [WIDTH-1:0]    w_raw_b;
    logic [WIDTH-1:0]    w_next_a;
    logic [WIDTH-1:0]    w_next_b;

    assign w_accept = bus.write & clock_valid & ~r_busy & ({1'b0, bus.write_addr} < W_DEPTH);

    // Out-of-range addresses read as zero rather than aliasing a real entry.
    always_comb begin
        w_old   = '0;
        w_raw_a = '0;
        w_raw_b = '0;
        if ({1'b0, bus.write_addr} < W_DEPTH)  w_old   = r_mem[bus.write_addr];
        if ({1'b0, bus.read_addr_a} < W_DEPTH) w_raw_a = r_mem[bus.read_addr_a];
        if ({1'b0, bus.read_addr_b} < W_DEPTH) w_raw_b = r_mem[bus.read_addr_b];
    end

    always_comb begin
        w_merged = w_old;
        for (int i = 0; i < NB; i++) begin
            if (bus.byte_en[i]) w_merged[8*i +: 8] = bus.write_data[8*i +: 8];
        end
    end

`ifdef REGISTER_BANK_READ_BYPASS_EN
    always_comb begin
        w_next_a = w_raw_a;
        w_next_b = w_raw_b;
        if (w_accept && bus.read_addr_a == bus.write_addr) w_next_a = w_merged;
        else if (r_busy && bus.read_addr_a == r_index)     w_next_a = RESET_VALUE;
        if (w_accept && bus.read_addr_b == bus.write_addr) w_next_b = w_merged;
        else if (r_busy && bus.read_addr_b == r_index)     w_next_b = RESET_VALUE;
    end
`else
    assign w_next_a = w_raw_a;
    assign w_next_b = w_raw_b;
`endif

    always_ff @(posedge clock) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= RESET_VALUE;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_busy  <= 1'b0;
            r_index <= '0;
            r_state <= ST_IDLE;
        end else if (clock_valid) begin
            r_rd_a <= w_next_a;
            r_rd_b <= w_next_b;
            if (w_accept) r_mem[bus.write_addr] <= w_merged;
            case (r_state)
                ST_IDLE: begin
                    if (bus.clear) begin
                        r_state <= ST_CLEARING;
                        r_busy  <= 1'b1;
                        r_index <= '0;
                    end
                end
                ST_CLEARING: begin
                    r_mem[r_index] <= RESET_VALUE;
                    if (r_index == W_LAST) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                        r_index <= '0;
                    end else begin
                        r_index <= r_index + 1'b1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.write_accept = w_accept;
    assign bus.busy         = r_busy;
    assign bus.read_data_a  = r_rd_a;
    assign bus.read_data_b  = r_rd_b;
endmodule

// File: tb/tb_register_bank.sv
// tb/tb_register_bank.sv - self-checking bench for register_bank at DEPTH 8 and DEPTH 6
module tb_register_bank;
    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic        reset;
    logic        clock_valid;
    logic        t_write;
    logic [2:0]  t_waddr;
    logic [31:0] t_wdata;
    logic [3:0]  t_be;
    logic        t_clear;
    logic [2:0]  t_ra;
    logic [2:0]  t_rb;

    register_bank_if #(.WIDTH(32), .ADDR_W(3)) bus8 ();
    register_bank_if #(.WIDTH(32), .ADDR_W(3)) bus6 ();

    register_bank #(.WIDTH(32), .DEPTH(8), .ADDR_W(3), .RESET_VALUE(32'h0)) u_dut8 (
        .clock(clock), .reset(reset), .clock_valid(clock_valid), .bus(bus8.slave));
    register_bank #(.WIDTH(32), .DEPTH(6), .ADDR_W(3), .RESET_VALUE(32'h0)) u_dut6 (
        .clock(clock), .reset(reset), .clock_valid(clock_valid), .bus(bus6.slave));

    assign bus8.write = t_write;       assign bus6.write = t_write;
    assign bus8.write_addr = t_waddr;  assign bus6.write_addr = t_waddr;
    assign bus8.write_data = t_wdata;  assign bus6.write_data = t_wdata;
    assign bus8.byte_en = t_be;        assign bus6.byte_en = t_be;
    assign bus8.clear = t_clear;       assign bus6.clear = t_clear;
    assign bus8.read_addr_a = t_ra;    assign bus6.read_addr_a = t_ra;
    assign bus8.read_addr_b = t_rb;    assign bus6.read_addr_b = t_rb;

    logic        o_acc  [2];
    logic        o_busy [2];
    logic [31:0] o_ra   [2];
    logic [31:0] o_rb   [2];
    assign o_acc[0] = bus8.write_accept;  assign o_acc[1] = bus6.write_accept;
    assign o_busy[0] = bus8.busy;         assign o_busy[1] = bus6.busy;
    assign o_ra[0] = bus8.read_data_a;    assign o_ra[1] = bus6.read_data_a;
    assign o_rb[0] = bus8.read_data_b;    assign o_rb[1] = bus6.read_data_b;

    int checks = 0;
    int errors = 0;

    // Reference: entry contents, clear progress as "entries still to clear", expected read regs
    int          dep [2] = '{8, 6};
    logic [31:0] m_mem [2][8];
    bit          m_busy [2] = '{0, 0};
    int          m_left [2] = '{0, 0};
    logic [31:0] m_ra [2];
    logic [31:0] m_rb [2];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rd(int u, logic [2:0] a);
        return (int'(a) < dep[u]) ? m_mem[u][a] : 32'h0;
    endfunction

    function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] be);
        logic [31:0] r = old;
        for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        return r;
    endfunction

    task automatic cyc(bit rstn, bit cv, bit wr, logic [2:0] wa, logic [31:0] wd,
                       logic [3:0] be, bit clr, logic [2:0] ra, logic [2:0] rb);
        reset = rstn; clock_valid = cv; t_write = wr; t_waddr = wa;
        t_wdata = wd; t_be = be; t_clear = clr; t_ra = ra; t_rb = rb;
        #2;
        for (int u = 0; u < 2; u++) begin
            bit          acc;
            int          cur;
            logic [31:0] na, nb;
            acc = wr && cv && !m_busy[u] && (int'(wa) < dep[u]);
            chk($sformatf("d%0d_accept", dep[u]), {31'b0, o_acc[u]}, {31'b0, acc});
            if (!rstn) begin
                for (int k = 0; k < 8; k++) m_mem[u][k] = 32'h0;
                m_busy[u] = 0; m_left[u] = 0; m_ra[u] = 32'h0; m_rb[u] = 32'h0;
            end else if (cv) begin
                cur = dep[u] - m_left[u];
                na = rd(u, ra);
                nb = rd(u, rb);
`ifdef REGISTER_BANK_READ_BYPASS_EN
                if (acc && ra == wa) na = merge(rd(u, wa), wd, be);
                else if (m_busy[u] && int'(ra) == cur) na = 32'h0;
                if (acc && rb == wa) nb = merge(rd(u, wa), wd, be);
                else if (m_busy[u] && int'(rb) == cur) nb = 32'h0;
`endif
                if (acc) m_mem[u][wa] = merge(rd(u, wa), wd, be);
                if (m_busy[u]) begin
                    m_mem[u][cur] = 32'h0;
                    m_left[u]--;
                    if (m_left[u] == 0) m_busy[u] = 0;
                end else if (clr) begin
                    m_busy[u] = 1;
                    m_left[u] = dep[u];
                end
                m_ra[u] = na;
                m_rb[u] = nb;
            end
        end
        @(posedge clock);
        #1;
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("d%0d_rda", dep[u]), o_ra[u], m_ra[u]);
            chk($sformatf("d%0d_rdb", dep[u]), o_rb[u], m_rb[u]);
            chk($sformatf("d%0d_busy", dep[u]), {31'b0, o_busy[u]}, {31'b0, m_busy[u]});
        end
    endtask

    task automatic idle(logic [2:0] ra, logic [2:0] rb);
        cyc(1, 1, 0, 3'd0, 32'h0, 4'h0, 0, ra, rb);
    endtask

    task automatic wr(logic [2:0] a, logic [31:0] d, logic [3:0] be);
        cyc(1, 1, 1, a, d, be, 0, a, 3'd0);
    endtask

    task automatic read_all();
        for (int i = 0; i < 8; i++) idle(3'(i), 3'(7 - i));
        idle(3'd0, 3'd0);
    endtask

    task automatic fill();
        for (int k = 0; k < 8; k++) wr(3'(k), 32'(k + 1), 4'hF);
    endtask

    initial begin
        int n;
        cyc(0, 1, 0, 3'd0, 32'h0, 4'h0, 0, 3'd0, 3'd0);
        cyc(0, 1, 0, 3'd0, 32'h0, 4'h0, 0, 3'd0, 3'd0);
        chk("reset_busy", {31'b0, bus8.busy}, 32'h0);
        read_all();

        wr(3'd3, 32'hAABBCCDD, 4'hF);
        wr(3'd3, 32'h11223344, 4'h5);
        idle(3'd3, 3'd3);
        chk("byte_en_merge", bus8.read_data_a, 32'hAA22CC44);

        wr(3'd5, 32'h0, 4'hF);
        cyc(1, 1, 1, 3'd5, 32'hDEADBEEF, 4'hF, 0, 3'd5, 3'd0);
`ifdef REGISTER_BANK_READ_BYPASS_EN
        chk("collision_same", bus8.read_data_a, 32'hDEADBEEF);
`else
        chk("collision_same", bus8.read_data_a, 32'h0);
`endif
        idle(3'd5, 3'd5);
        chk("collision_next", bus8.read_data_a, 32'hDEADBEEF);

        fill();
        cyc(1, 1, 0, 3'd0, 32'h0, 4'h0, 1, 3'd0, 3'd1);
        n = bus8.busy ? 1 : 0;
        cyc(1, 1, 1, 3'd7, 32'hFFFFFFFF, 4'hF, 1, 3'd7, 3'd0);
        if (bus8.busy) n++;
        for (int i = 0; i < 10; i++) begin
            idle(3'(i), 3'(7 - i));
            if (bus8.busy) n++;
        end
        chk("busy_cycles", 32'(n), 32'd8);
        read_all();

        fill();
        cyc(1, 1, 0, 3'd0, 32'h0, 4'h0, 1, 3'd0, 3'd7);
        idle(3'd1, 3'd6);
        idle(3'd2, 3'd5);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 3'd6, 32'h55, 4'hF, 1, 3'(i), 3'd7);
        chk("gated_busy", {31'b0, bus8.busy}, 32'h1);
        n = 0;
        while ((m_busy[0] || m_busy[1]) && n < 20) begin
            idle(3'(n), 3'd7);
            n++;
        end
        chk("gated_done", 32'(n), 32'd6);
        read_all();

        fill();
        cyc(1, 1, 0, 3'd0, 32'h0, 4'h0, 1, 3'd0, 3'd0);
        idle(3'd4, 3'd5);
        idle(3'd4, 3'd5);
        cyc(0, 1, 0, 3'd0, 32'h0, 4'h0, 0, 3'd4, 3'd5);
        chk("midclear_busy6", {31'b0, bus6.busy}, 32'h0);
        read_all();
        cyc(1, 1, 1, 3'd7, 32'h12345678, 4'hF, 0, 3'd6, 3'd7);
        chk("oor_accept6", {31'b0, bus6.write_accept}, 32'h0);
        chk("oor_read6", bus6.read_data_a, 32'h0);

        for (int i = 0; i < 400; i++) begin
            logic [2:0] wa;
            wa = 3'($urandom_range(0, 7));
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
                wa, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 15) == 0,
                ($urandom_range(0, 1) != 0) ? wa : 3'($urandom_range(0, 7)),
                3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
